// File: rtl/mci_sram_pkg.sv
// MCI SRAM controller shared types and SECDED helpers.
// Code is Hamming(38,32) by bit position plus an overall parity bit in ecc[6].
package mci_sram_pkg;

  localparam int MCI_DW     = 32;
  localparam int ECC_WIDTH  = 7;
  localparam int CODE_WIDTH = MCI_DW + ECC_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RMW_MERGE
  } mci_sram_arb_state_e;

  // Codeword position of data bit j: the j-th non-power-of-two in 3..38.
  function automatic logic [5:0] data_pos(input int j);
    logic [5:0] pos;
    int         cnt;
    pos = '0;
    cnt = 0;
    for (int k = 3; k < 39; k++) begin
      if ((k & (k - 1)) != 0) begin
        if (cnt == j) pos = 6'(k);
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [5:0][MCI_DW-1:0] build_h();
    logic [5:0][MCI_DW-1:0] h;
    logic [5:0]             p;
    h = '0;
    for (int j = 0; j < MCI_DW; j++) begin
      p = data_pos(j);
      for (int i = 0; i < 6; i++) h[i][j] = p[i];
    end
    return h;
  endfunction

  localparam logic [5:0][MCI_DW-1:0] H_MAT = build_h();

  function automatic logic [5:0] ecc_hamming(input logic [MCI_DW-1:0] d);
    logic [5:0] p;
    p = '0;
    for (int i = 0; i < 6; i++) p[i] = ^(d & H_MAT[i]);
    return p;
  endfunction

  function automatic logic [ECC_WIDTH-1:0] ecc_encode(
    input logic [MCI_DW-1:0] d
  );
    logic [5:0] p;
    p = ecc_hamming(d);
    return {^{d, p}, p};
  endfunction

  // s[6]=1: odd error count (single); s[6]=0 with s[5:0]!=0: double.
  function automatic logic [ECC_WIDTH-1:0] ecc_syndrome(
    input logic [MCI_DW-1:0]    d,
    input logic [ECC_WIDTH-1:0] e
  );
    logic [5:0] p;
    p = ecc_hamming(d);
    return {^{d, e}, e[5:0] ^ p};
  endfunction

endpackage

// File: rtl/mci_sram_arb_ctrl_secded.sv
// SECDED encoder plus syndrome decoder/corrector, purely combinational.
// Double errors pass the raw data through untouched.
module mci_sram_secded
  import mci_sram_pkg::*;
(
  input  logic [MCI_DW-1:0]    data_i,
  input  logic [ECC_WIDTH-1:0] ecc_i,
  output logic [ECC_WIDTH-1:0] ecc_o,
  output logic [MCI_DW-1:0]    data_o,
  output logic                 sb_o,
  output logic                 db_o
);

  logic [ECC_WIDTH-1:0] syn;

  assign ecc_o = ecc_encode(data_i);
  assign syn   = ecc_syndrome(data_i, ecc_i);

  always_comb begin
    data_o = data_i;
    sb_o   = 1'b0;
    db_o   = 1'b0;
    if (syn[6]) begin
      sb_o = 1'b1;
      for (int j = 0; j < MCI_DW; j++) begin
        if (data_pos(j) == syn[5:0]) data_o[j] = ~data_i[j];
      end
    end else if (syn[5:0] != '0) begin
      db_o = 1'b1;
    end
  end

endmodule

// File: rtl/mci_sram_arb_ctrl.sv
// Round-robin arbiter and SECDED controller for the shared MCI SRAM.
// Partial writes run as read, merge, write through RMW_MERGE.
module mci_sram_arb_ctrl
  import mci_sram_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_REQ-1:0]                    req_i,
  input  logic [NUM_REQ-1:0]                    we_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
  input  logic [NUM_REQ-1:0][3:0]               wstrb_i,
  output logic [NUM_REQ-1:0]                    gnt_o,
  output logic [NUM_REQ-1:0]                    rvalid_o,
  output logic [DATA_WIDTH-1:0]                 rdata_o,
  output logic                                  sb_err_o,
  output logic                                  db_err_o,
  output logic [ADDR_WIDTH-1:0]                 err_addr_o,
  output logic                                  sram_cs_o,
  output logic                                  sram_we_o,
  output logic [ADDR_WIDTH-1:0]                 sram_addr_o,
  output logic [DATA_WIDTH+ECC_WIDTH-1:0]       sram_wdata_o,
  input  logic [DATA_WIDTH+ECC_WIDTH-1:0]       sram_rdata_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  mci_sram_arb_state_e   state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MCI_DW-1:0]     wdata_q, wdata_d;
  logic [3:0]            strb_q, strb_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic                  win_vld;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      ci;
  int                    c;

  logic [MCI_DW-1:0]     dec_data;
  logic                  dec_sb, dec_db;
  logic [MCI_DW-1:0]     merged;
  logic [MCI_DW-1:0]     enc_in;
  logic [ECC_WIDTH-1:0]  enc_ecc;

  logic [ECC_WIDTH-1:0]  unused_dec_ecc;
  logic [MCI_DW-1:0]     unused_enc_data;
  logic                  unused_enc_sb, unused_enc_db;

  // Scan downward so the nearest requester after last_q wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    c       = 0;
    ci      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c  = (int'(last_q) + k) % NUM_REQ;
      ci = IDX_W'(c);
      if (req_i[ci]) begin
        win_vld = 1'b1;
        win_idx = ci;
      end
    end
  end

  mci_sram_secded u_dec (
    .data_i (sram_rdata_i[MCI_DW-1:0]),
    .ecc_i  (sram_rdata_i[CODE_WIDTH-1:MCI_DW]),
    .ecc_o  (unused_dec_ecc),
    .data_o (dec_data),
    .sb_o   (dec_sb),
    .db_o   (dec_db)
  );

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = strb_q[b] ? wdata_q[8*b +: 8]
                                   : dec_data[8*b +: 8];
    end
  end

  assign enc_in = (state_q == ST_RMW_MERGE) ? merged : wdata_i[win_idx];

  mci_sram_secded u_enc (
    .data_i (enc_in),
    .ecc_i  ('0),
    .ecc_o  (enc_ecc),
    .data_o (unused_enc_data),
    .sb_o   (unused_enc_sb),
    .db_o   (unused_enc_db)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    err_addr_d   = err_addr_q;
    gnt_o        = '0;
    rvalid_o     = '0;
    rdata_o      = '0;
    sb_err_o     = 1'b0;
    db_err_o     = 1'b0;
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          gnt_o[win_idx] = 1'b1;
          last_d         = win_idx;
          owner_d        = win_idx;
          addr_d         = addr_i[win_idx];
          wdata_d        = wdata_i[win_idx];
          strb_d         = wstrb_i[win_idx];
          sram_addr_o    = addr_i[win_idx];
          if (!we_i[win_idx]) begin
            sram_cs_o = 1'b1;
            state_d   = ST_RD_WAIT;
          end else if (wstrb_i[win_idx] == 4'hF) begin
            sram_cs_o    = 1'b1;
            sram_we_o    = 1'b1;
            sram_wdata_o = {enc_ecc, wdata_i[win_idx]};
          end else if (wstrb_i[win_idx] != 4'h0) begin
            sram_cs_o = 1'b1;
            state_d   = ST_RMW_MERGE;
          end
        end
      end
      ST_RD_WAIT: begin
        rvalid_o[owner_q] = 1'b1;
        rdata_o           = dec_data;
        sb_err_o          = dec_sb;
        db_err_o          = dec_db;
        state_d           = ST_IDLE;
      end
      ST_RMW_MERGE: begin
        sb_err_o = dec_sb;
        db_err_o = dec_db;
        state_d  = ST_IDLE;
        // An uncorrectable old word must not be rewritten with fresh ECC.
        if (!dec_db) begin
          sram_cs_o    = 1'b1;
          sram_we_o    = 1'b1;
          sram_addr_o  = addr_q;
          sram_wdata_o = {enc_ecc, merged};
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (sb_err_o || db_err_o) err_addr_d = addr_q;
    if (rst_i) begin
      gnt_o        = '0;
      sram_cs_o    = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      owner_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_mci_sram_arb_ctrl.sv
// Scoreboard bench for mci_sram_arb_ctrl with a behavioural SRAM.
// Inputs change at posedge+1; outputs are sampled at negedge.
module tb_mci_sram_arb_ctrl;

  localparam int NR    = 2;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int LIM   = 50;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NR-1:0]       req = '0;
  logic [NR-1:0]       we  = '0;
  logic [NR-1:0][AW-1:0] addr  = '0;
  logic [NR-1:0][31:0] wdata = '0;
  logic [NR-1:0][3:0]  wstrb = '0;
  logic [NR-1:0]       gnt_o, rvalid_o;
  logic [31:0]         rdata_o;
  logic                sb_err_o, db_err_o;
  logic [AW-1:0]       err_addr_o;
  logic                sram_cs_o, sram_we_o;
  logic [AW-1:0]       sram_addr_o;
  logic [38:0]         sram_wdata_o;
  logic [38:0]         rdq = '0;

  logic [38:0]         mem [DEPTH];
  logic                mem_clr = 1'b1;
  logic                flip_req = 1'b0;
  logic [AW-1:0]       flip_addr = '0;
  logic [38:0]         flip_mask = '0;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          gnt_seq[$];
  int          gcyc [NR];
  logic [31:0] shadow [DEPTH];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int wr_cnt = 0, cs_cnt = 0, sb_cnt = 0, db_cnt = 0;

  mci_sram_arb_ctrl #(.NUM_REQ(NR), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .wstrb_i      (wstrb),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .sb_err_o     (sb_err_o),
    .db_err_o     (db_err_o),
    .err_addr_o   (err_addr_o),
    .sram_cs_o    (sram_cs_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (rdq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flip_req) begin
      mem[flip_addr] <= mem[flip_addr] ^ flip_mask;
    end else if (sram_cs_o && sram_we_o) begin
      mem[sram_addr_o] <= sram_wdata_o;
    end
    if (sram_cs_o && !sram_we_o) rdq <= mem[sram_addr_o];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid_o != '0) begin
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", 64'(rvalid_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_owner", 64'(rvalid_o), 64'(1) << e.idx);
          chk("rdata", 64'(rdata_o), 64'(e.data));
          chk("rvalid_latency", 64'(cyc), 64'(e.cyc + 1));
        end
      end
      if (gnt_o != '0) chk("gnt_onehot", 64'($onehot(gnt_o)), 64'd1);
      for (int r = 0; r < NR; r++) begin
        if (gnt_o[r]) begin
          gnt_seq.push_back(r);
          gcyc[r] = cyc;
          if (!we[r]) begin
            exp_q.push_back('{r, shadow[addr[r]], cyc});
          end else begin
            for (int b = 0; b < 4; b++)
              if (wstrb[r][b])
                shadow[addr[r]][8*b +: 8] = wdata[r][8*b +: 8];
          end
        end
      end
      if (sram_cs_o) cs_cnt++;
      if (sram_cs_o && sram_we_o) wr_cnt++;
      if (sb_err_o) sb_cnt++;
      if (db_err_o) db_cnt++;
    end
  end

  task automatic issue(input int r, input logic w, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    int n;
    we[r] = w;
    addr[r] = a;
    wdata[r] = d;
    wstrb[r] = s;
    req[r] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt_o[r] && n < LIM);
    chk("gnt_wait", 64'(gnt_o[r]), 64'd1);
    @(posedge clk);
    #1;
    req[r] = 1'b0;
  endtask

  task automatic inject(input logic [AW-1:0] a, input logic [38:0] m);
    flip_addr = a;
    flip_mask = m;
    flip_req  = 1'b1;
    @(posedge clk);
    #1;
    flip_req  = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, w0, s0, d0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    req[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_cs", 64'(sram_cs_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_err_addr", 64'(err_addr_o), 64'd0);
    @(posedge clk);
    #1;
    req = '0;
    mem_clr = 1'b0;
    rst = 1'b0;

    w0 = wr_cnt;
    issue(0, 1'b1, 6'd5, 32'hA5A5_1234, 4'hF);
    issue(0, 1'b0, 6'd5, 32'h0, 4'h0);
    settle();
    chk("t1_wr_cnt", 64'(wr_cnt - w0), 64'd1);
    chk("t1_mem5", 64'(mem[5][31:0]), 64'hA5A5_1234);
    chk("t1_no_err", 64'(sb_cnt + db_cnt), 64'd0);
    chk("t1_drain", 64'(exp_q.size()), 64'd0);

    for (int i = 0; i < 8; i++)
      issue(1, 1'b1, 6'(20 + i), 32'hC0DE_0000 + 32'(i), 4'hF);
    gnt_seq.delete();
    fork
      for (int i = 0; i < 4; i++) issue(0, 1'b0, 6'(20 + i), 32'h0, 4'h0);
      for (int j = 0; j < 4; j++) issue(1, 1'b0, 6'(24 + j), 32'h0, 4'h0);
    join
    settle();
    chk("t2_ngnt", 64'(gnt_seq.size()), 64'd8);
    for (int i = 0; i < gnt_seq.size(); i++)
      chk("t2_order", 64'(gnt_seq[i]), 64'(i % 2));
    chk("t2_drain", 64'(exp_q.size()), 64'd0);

    issue(1, 1'b1, 6'd9, 32'h1122_3344, 4'hF);
    gnt_seq.delete();
    fork
      issue(0, 1'b1, 6'd9, 32'hFFFF_FFFF, 4'b0101);
      issue(1, 1'b0, 6'd9, 32'h0, 4'h0);
    join
    settle();
    chk("t3_first", 64'(gnt_seq[0]), 64'd0);
    chk("t3_blocked", 64'(gcyc[1] - gcyc[0]), 64'd2);
    chk("t3_mem9", 64'(mem[9][31:0]), 64'h11FF_33FF);
    chk("t3_no_err", 64'(sb_cnt + db_cnt), 64'd0);
    chk("t3_drain", 64'(exp_q.size()), 64'd0);

    issue(0, 1'b1, 6'd3, 32'hDEAD_BEEF, 4'hF);
    inject(6'd3, 39'h80);
    s0 = sb_cnt;
    d0 = db_cnt;
    issue(0, 1'b0, 6'd3, 32'h0, 4'h0);
    settle();
    chk("t4_sb_pulse", 64'(sb_cnt - s0), 64'd1);
    chk("t4_sb_no_db", 64'(db_cnt - d0), 64'd0);
    chk("t4_err_addr", 64'(err_addr_o), 64'd3);
    chk("t4_drain", 64'(exp_q.size()), 64'd0);

    issue(0, 1'b1, 6'd3, 32'h0F0F_0F0F, 4'hF);
    inject(6'd3, 39'h10_0001);
    d0 = db_cnt;
    w0 = wr_cnt;
    issue(0, 1'b1, 6'd3, 32'h0000_00FF, 4'b0001);
    settle();
    chk("t4_db_pulse", 64'(db_cnt - d0), 64'd1);
    chk("t4_db_no_wr", 64'(wr_cnt - w0), 64'd0);
    chk("t4_db_mem", 64'(mem[3][31:0]), 64'h0F1F_0F0E);
    shadow[3] = 32'h0F0F_0F0F ^ 32'h0010_0001;
    issue(0, 1'b0, 6'd3, 32'h0, 4'h0);
    settle();
    chk("t4_db_read", 64'(db_cnt - d0), 64'd2);
    chk("t4_db_err_addr", 64'(err_addr_o), 64'd3);

    issue(0, 1'b1, 6'd40, 32'h1234_5678, 4'b0011);
    rst = 1'b1;
    we  = '0;
    req = '1;
    @(negedge clk);
    chk("t5_we", 64'(sram_we_o), 64'd0);
    chk("t5_cs", 64'(sram_cs_o), 64'd0);
    chk("t5_gnt", 64'(gnt_o), 64'd0);
    chk("t5_rvalid", 64'(rvalid_o), 64'd0);
    chk("t5_db", 64'(db_err_o), 64'd0);
    chk("t5_err_addr", 64'(err_addr_o), 64'd0);
    @(posedge clk);
    #1;
    req = '0;
    rst = 1'b0;
    shadow[40] = '0;
    chk("t5_mem40", 64'(mem[40]), 64'd0);
    gnt_seq.delete();
    fork
      issue(1, 1'b0, 6'd20, 32'h0, 4'h0);
      issue(0, 1'b0, 6'd21, 32'h0, 4'h0);
    join
    settle();
    chk("t5_first", 64'(gnt_seq[0]), 64'd0);
    chk("t5_second", 64'(gnt_seq[1]), 64'd1);

    c0 = cs_cnt;
    issue(0, 1'b1, 6'd50, 32'hFFFF_FFFF, 4'h0);
    settle();
    chk("t6_no_cs", 64'(cs_cnt - c0), 64'd0);
    chk("t6_mem50", 64'(mem[50]), 64'd0);

    chk("final_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
